dram_responder: RTL
===================

# dram_responder

AXI4-Lite-style responder for the 64-bit DRAM window driven by the team's bridge initiator. It accepts read requests on AR/R and write requests on AW/W/B, and backs them with an internal 256 x 64-bit register memory after a programmable latency. It is the memory-side end of the bridge link and serves as both the simulation DRAM model and the synthesizable scratch store.

## Interface
- LATENCY, 2: cycles from the address/data handshake to R_VALID/B_VALID; legal range 1..255.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- AR_VALID  in  1  read address valid.
- AR_ADDR  in  17  read byte address {6'b100000, index[7:0], 3'b000}.
- AR_READY  out  1  read address accepted.
- R_VALID  out  1  read data valid.
- R_DATA  out  64  read data.
- R_RESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- R_READY  in  1  initiator accepts read data.
- AW_VALID  in  1  write address valid.
- AW_ADDR  in  17  write byte address, same format as AR_ADDR.
- AW_READY  out  1  write address accepted.
- W_VALID  in  1  write data valid.
- W_DATA  in  64  write data.
- W_READY  out  1  write data accepted.
- B_VALID  out  1  write response valid.
- B_RESP  out  2  write response code.
- B_READY  in  1  initiator accepts response.

## Operation
- FSM states:
  - IDLE: if AR_VALID, go to R_LAT (a read wins over a simultaneous AW_VALID). Else if AW_VALID, go to W_DATA.
  - R_LAT: count LATENCY-1 cycles, then go to R_RESP_ST.
  - R_RESP_ST: on R_READY, go to IDLE.
  - W_DATA: on W_VALID, go to W_LAT.
  - W_LAT: count LATENCY-1 cycles, then go to B_RESP_ST.
  - B_RESP_ST: on B_READY, go to IDLE.
- AR_READY = (state==IDLE) & AR_VALID, combinational. The address is latched on that handshake.
- AW_READY = (state==IDLE) & AW_VALID & ~AR_VALID, combinational. The address is latched on that handshake.
- W_READY = (state==W_DATA), combinational. W_DATA is captured on W_VALID & W_READY, and the memory is written at that same edge.
- Read data is taken from the memory at the AR handshake.
  - R_DATA is registered and held stable while R_VALID is high.
  - R_DATA returns to 0 after the handshake.
- Memory index is ADDR[10:3]; the low 3 bits are ignored unless DRAM_ADDR_CHECK_EN is defined.
- Latency counter is 8 bits and is loaded with LATENCY-1 on entry to R_LAT/W_LAT.
- Reset behaviour:
  - State goes to IDLE.
  - R_VALID, B_VALID, R_DATA and both RESP outputs go to 0.
  - Memory contents are not reset.
  - A reset mid-transaction drops the transaction. A write whose W handshake already completed stays in memory.

## Timing
- Read: AR handshake at cycle t. R_VALID is high from t+LATENCY until the cycle R_READY is sampled high, inclusive. The next AR_READY is possible at the cycle after the R handshake.
- Write: AW handshake at t, so W_READY is high from t+1. W handshake at u, so B_VALID is high from u+LATENCY until the B_READY handshake.
- R_READY or B_READY already high when VALID rises: the handshake completes in that first VALID cycle.
- Read-after-write to the same index returns the new data, because the write completes before B_VALID.
- Only one transaction is outstanding at a time. AW_READY and AR_READY are 0 outside IDLE.

## Configuration
- DRAM_ADDR_CHECK_EN defined:
  - A request with ADDR[16:11]!=6'b100000 or ADDR[2:0]!=0 gets SLVERR (2'b10).
  - On such a read, R_DATA=0.
  - On such a write, the memory write is suppressed.
  - Handshake timing is unchanged.
- DRAM_ADDR_CHECK_EN undefined: no checking; R_RESP and B_RESP are always 2'b00.

## Test plan
- Reset, then write index 8'h05 with 64'hDEAD_BEEF_0123_4567, then read index 8'h05 -> R_DATA=64'hDEAD_BEEF_0123_4567, R_RESP=0, R_VALID rising LATENCY cycles after the AR handshake.
- AR_VALID and AW_VALID asserted in the same IDLE cycle -> AR_READY=1, AW_READY=0; the write is accepted only after the R handshake.
- R_READY held low for 5 cycles after R_VALID -> R_VALID and R_DATA stay stable, and the FSM stays in R_RESP_ST.
- W_VALID delayed 3 cycles after the AW handshake -> W_READY stays high throughout, and B_VALID rises LATENCY cycles after W_VALID.
- rst pulsed during W_LAT -> B_VALID=0 and state is IDLE next cycle; a read of that index returns the written data.
- With DRAM_ADDR_CHECK_EN: write to AW_ADDR=17'h0_0001 -> B_RESP=2'b10 and memory index 0 unchanged.

Source files
------------

// File: rtl/dram_responder.sv
// Single-outstanding AXI4-Lite-style responder over a 256 x 64-bit store with programmable latency.
// Optional address checking (SLVERR on bad region/alignment) is enabled by defining DRAM_ADDR_CHECK_EN.
module dram_responder #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_R_LAT  = 3'd1;
  localparam logic [2:0] S_R_RESP = 3'd2;
  localparam logic [2:0] S_W_DATA = 3'd3;
  localparam logic [2:0] S_W_LAT  = 3'd4;
  localparam logic [2:0] S_B_RESP = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
  // With LATENCY==1 there are no wait cycles, so the latency states are bypassed entirely.
  localparam logic [2:0] R_NEXT = (LATENCY == 1) ? S_R_RESP : S_R_LAT;
  localparam logic [2:0] W_NEXT = (LATENCY == 1) ? S_B_RESP : S_W_LAT;

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_widx;
  logic        r_wbad;
  logic [63:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [1:0]  r_bresp;
  logic [63:0] r_mem [256];

  logic [7:0]  w_ar_idx;
  logic [7:0]  w_aw_idx;
  logic        w_ar_bad;
  logic        w_aw_bad;
  logic        w_w_hs;

  assign w_ar_idx = AR_ADDR[10:3];
  assign w_aw_idx = AW_ADDR[10:3];

`ifdef DRAM_ADDR_CHECK_EN
  assign w_ar_bad = (AR_ADDR[16:11] != 6'b100000) || (AR_ADDR[2:0] != 3'b000);
  assign w_aw_bad = (AW_ADDR[16:11] != 6'b100000) || (AW_ADDR[2:0] != 3'b000);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{AR_ADDR[16:11], AR_ADDR[2:0], AW_ADDR[16:11], AW_ADDR[2:0]};
  assign w_ar_bad = 1'b0;
  assign w_aw_bad = 1'b0;
`endif

  assign AR_READY = (r_state == S_IDLE) & AR_VALID;
  assign AW_READY = (r_state == S_IDLE) & AW_VALID & ~AR_VALID;
  assign W_READY  = (r_state == S_W_DATA);
  assign R_VALID  = (r_state == S_R_RESP);
  assign B_VALID  = (r_state == S_B_RESP);
  assign R_DATA   = r_rdata;
  assign R_RESP   = r_rresp;
  assign B_RESP   = r_bresp;
  assign w_w_hs   = W_READY & W_VALID;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_widx  <= '0;
      r_wbad  <= 1'b0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_bresp <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (AR_VALID) begin
            r_state <= R_NEXT;
            r_cnt   <= LAT_LOAD;
            r_rdata <= w_ar_bad ? '0 : r_mem[w_ar_idx];
            r_rresp <= w_ar_bad ? RESP_SLVERR : RESP_OKAY;
          end else if (AW_VALID) begin
            r_state <= S_W_DATA;
            r_widx  <= w_aw_idx;
            r_wbad  <= w_aw_bad;
            r_bresp <= w_aw_bad ? RESP_SLVERR : RESP_OKAY;
          end
        end
        S_R_LAT: begin
          if (r_cnt <= 8'd1) r_state <= S_R_RESP;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        S_R_RESP: begin
          if (R_READY) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
          end
        end
        S_W_DATA: begin
          if (W_VALID) begin
            r_state <= W_NEXT;
            r_cnt   <= LAT_LOAD;
          end
        end
        S_W_LAT: begin
          if (r_cnt <= 8'd1) r_state <= S_B_RESP;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        S_B_RESP: begin
          if (B_READY) begin
            r_state <= S_IDLE;
            r_bresp <= RESP_OKAY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; a completed W handshake persists across a later reset.
  always_ff @(posedge clk) begin
    if (!rst && w_w_hs && !r_wbad) r_mem[r_widx] <= W_DATA;
  end

endmodule
